// File: rtl/jtag_master_shifter.sv
// jtag_master_shifter: JTAG initiator that runs one IR or DR scan per request.
// It starts from Run-Test/Idle and parks the TAP there again after the scan.
// Ports:
//   clk_i, trst_ni           system clock; asynchronous active-low reset
//   req_valid_i/req_ready_o  scan request handshake
//   req_ir_i                 1 = IR scan, 0 = DR scan
//   req_len_i                scan length minus 1 (clamped to MAX_LEN-1)
//   req_data_i               TDI bits, bit 0 shifted first
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_data_o               captured TDO bits, bit 0 sampled first
//   tck_o, tms_o, tdi_o      JTAG outputs to the target TAP
//   tdo_i                    JTAG data from the target TAP
//   trst_no                  TAP reset, a combinational copy of trst_ni
module jtag_master_shifter #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic                       clk_i,
    input  logic                       trst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_ir_i,
    input  logic [$clog2(MAX_LEN)-1:0] req_len_i,
    input  logic [MAX_LEN-1:0]         req_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [MAX_LEN-1:0]         rsp_data_o,
    output logic                       tck_o,
    output logic                       tms_o,
    output logic                       tdi_o,
    input  logic                       tdo_i,
    output logic                       trst_no
);
    localparam int LW = $clog2(MAX_LEN);
    localparam int PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        ST_RESET, ST_IDLE, ST_SEL_DR, ST_SEL_IR, ST_CAPTURE,
        ST_SHIFT, ST_UPDATE, ST_RTI, ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [2:0]        rcnt_q, rcnt_d;
    logic [LW-1:0]     bit_q, bit_d, len_q, len_d;
    logic              ir_q, ir_d, tck_q, tck_d, tdi_q, tdi_d;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d;
    logic              stepping, step_end, last_bit;

    // Every state except IDLE and RESP is one or more TAP steps long.
    assign stepping = state_q != ST_IDLE && state_q != ST_RESP;
    assign step_end = stepping && phase_q == PH_LAST;
    assign last_bit = bit_q == len_q;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        bit_d   = bit_q;
        len_d   = len_q;
        ir_d    = ir_q;
        data_d  = data_q;
        cap_d   = cap_q;
        phase_d = stepping ? (step_end ? '0 : phase_q + 1'b1) : '0;
        case (state_q)
            ST_RESET: if (step_end) begin
                rcnt_d = rcnt_q + 3'd1;
                if (rcnt_q == 3'd5) state_d = ST_IDLE;
            end
            ST_IDLE: if (req_valid_i) begin
                state_d = ST_SEL_DR;
                ir_d    = req_ir_i;
                len_d   = ({1'b0, req_len_i} >= (LW+1)'(MAX_LEN)) ? LW'(MAX_LEN - 1) : req_len_i;
                data_d  = req_data_i;
                cap_d   = '0;
            end
            ST_SEL_DR:  if (step_end) state_d = ir_q ? ST_SEL_IR : ST_CAPTURE;
            ST_SEL_IR:  if (step_end) state_d = ST_CAPTURE;
            ST_CAPTURE: if (step_end) begin
                state_d = ST_SHIFT;
                bit_d   = '0;
            end
            ST_SHIFT: begin
                // TDO is taken on the same clk edge that raises tck.
                if (phase_q == PH_RISE) cap_d[bit_q] = tdo_i;
                if (step_end) begin
                    if (last_bit) state_d = ST_UPDATE;
                    else bit_d = bit_q + 1'b1;
                end
            end
            ST_UPDATE: if (step_end) state_d = ST_RTI;
            ST_RTI:    if (step_end) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
        // New TDI bit is presented at the start of each shift step, held otherwise.
        tdi_d = (step_end && state_d == ST_SHIFT) ? data_q[bit_d] : tdi_q;
        tck_d = phase_d >= PH_HIGH;
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= ST_RESET;
            phase_q <= '0;
            rcnt_q  <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            ir_q    <= 1'b0;
            data_q  <= '0;
            cap_q   <= '0;
            tck_q   <= 1'b0;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rcnt_q  <= rcnt_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            ir_q    <= ir_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            tck_q   <= tck_d;
            tdi_q   <= tdi_d;
        end
    end

    // TMS depends only on the current step, so it changes with the step start.
    always_comb begin
        tms_o = (state_q == ST_RESET) ? (rcnt_q != 3'd5) :
                (state_q == ST_SEL_DR || state_q == ST_SEL_IR || state_q == ST_UPDATE) ? 1'b1 :
                (state_q == ST_SHIFT) ? last_bit : 1'b0;
    end

    assign req_ready_o = state_q == ST_IDLE;
    assign rsp_valid_o = state_q == ST_RESP;
    assign rsp_data_o  = rsp_valid_o ? cap_q : '0;
    assign tck_o       = tck_q;
    assign tdi_o       = tdi_q;
    assign trst_no     = trst_ni;
endmodule

// File: tb/tb_jtag_master_shifter.sv
// tb_jtag_master_shifter: directed scans against a TAP model with a response scoreboard.
module tb_jtag_master_shifter;
    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 32;
    localparam logic [31:0] IDCODE = 32'h2495_11C3;
    localparam logic [3:0] TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7,
                           UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic        clk_i = 1'b0, trst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o, req_ir_i = 1'b0;
    logic [4:0]  req_len_i = '0;
    logic [31:0] req_data_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b1;
    logic [31:0] rsp_data_o;
    logic        tck_o, tms_o, tdi_o, tdo_i, trst_no;

    jtag_master_shifter #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .clk_i(clk_i), .trst_ni(trst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ir_i(req_ir_i), .req_len_i(req_len_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i), .trst_no(trst_no)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // TAP model: captures on entry to Capture, shifts on every rise in Capture/Shift.
    // After reset its instruction is BYPASS; IR value 1 selects IDCODE.
    logic [3:0]  tap, tap_nx;
    logic [4:0]  ir, irsr;
    logic [31:0] idsr;
    logic        byp;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    assign tap_nx = tap_next(tap, tms_o);
    assign tdo_i  = (tap == CIR || tap == SHIR) ? irsr[0] :
                    (tap == CDR || tap == SHDR) ? (ir == 5'h01 ? idsr[0] : byp) : 1'b0;

    always @(posedge tck_o or negedge trst_no) begin
        if (!trst_no) begin
            tap <= TLR; ir <= 5'h1F; irsr <= '0; idsr <= '0; byp <= 1'b0;
        end else begin
            tap <= tap_nx;
            if (tap_nx == CDR) begin
                byp <= 1'b0; idsr <= IDCODE;
            end else if (tap == CDR || tap == SHDR) begin
                byp <= tdi_o; idsr <= {tdi_o, idsr[31:1]};
            end
            if (tap_nx == CIR) irsr <= 5'h01;
            else if (tap == CIR || tap == SHIR) irsr <= {tdi_o, irsr[4:1]};
            if (tap_nx == UIR) ir <= irsr;
            if (tap_nx == TLR) ir <= 5'h1F;
        end
    end

    // Records TMS at every tck rise since the last accept or reset.
    logic [63:0] tms_acc;
    int          tms_n;
    logic        tck_prev;
    always @(posedge clk_i) begin
        tck_prev <= tck_o;
        if (!trst_ni || (req_valid_i && req_ready_o)) begin
            tms_n <= 0; tms_acc <= '0;
        end else if (tck_o && !tck_prev) begin
            if (tms_n < 64) tms_acc[tms_n[5:0]] <= tms_o;
            tms_n <= tms_n + 1;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [63:0] tms;
        int          steps;
        int          lat;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    time  acc_time;
    logic in_rsp = 1'b0;

    always @(negedge clk_i) begin
        if (rsp_valid_o && !in_rsp) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL spurious_rsp: got data %0h, expected no response", rsp_data_o);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", rsp_data_o, mon_e.data);
                check("tms_seq", tms_acc, mon_e.tms);
                check("tck_steps", tms_n, mon_e.steps);
                check("latency", int'(($time - acc_time - 5) / 10), mon_e.lat);
            end
        end
        in_rsp <= rsp_valid_o;
    end

    task automatic scan(input logic ir_s, input logic [4:0] len, input logic [31:0] data,
                        input logic [31:0] ed, input logic [63:0] et, input int steps);
        exp_t e;
        int n;
        e.data = ed; e.tms = et; e.steps = steps; e.lat = steps * 2 * CLK_DIV;
        sb.push_back(e);
        req_ir_i = ir_s; req_len_i = len; req_data_i = data; req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 2000) begin @(negedge clk_i); n++; end
        if (!req_ready_o) begin
            n_chk++; n_fail++;
            $display("FAIL req_accept: got ready=0 after %0d cycles, expected ready=1", n);
        end
        acc_time = $time + 5;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready_o && n < 2000) begin @(negedge clk_i); n++; end
        check("wait_idle", req_ready_o, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {req_ready_o, rsp_valid_o, tck_o, tms_o, tdi_o, trst_no}, 6'b000100);
        check({tag, "_rsp_data"}, rsp_data_o, 0);
    endtask

    task automatic reset_release(input string tag);
        int n = 0;
        logic vseen = 1'b0, tck_hi = 1'b0, rdy_lo = 1'b0;
        trst_ni = 1'b1;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
            vseen |= rsp_valid_o;
        end
        check({tag, "_seq_cycles"}, n, 24);
        check({tag, "_seq_pulses"}, tms_n, 6);
        check({tag, "_seq_tms"}, tms_acc, 64'h1F);
        check({tag, "_seq_no_rsp"}, vseen, 1'b0);
        repeat (8) begin
            @(negedge clk_i);
            tck_hi |= tck_o;
            rdy_lo |= !req_ready_o;
        end
        check({tag, "_idle_tck_rdy"}, {tck_hi, rdy_lo}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] snap;
        logic        stable;
        int          n;
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        reset_release("por");

        // Bypass: one TCK of delay with 0 captured, so result is data<<1 truncated.
        scan(1'b0, 5'd7, 32'hDEAD_00A5, 32'h0000_004A, 64'h601, 12);
        scan(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 64'hD, 5);

        // Response held off for 50 cycles.
        wait_idle();
        rsp_ready_i = 1'b0;
        scan(1'b0, 5'd15, 32'h5555_1234, 32'h0000_2468, 64'h6_0001, 20);
        n = 0;
        while (!rsp_valid_o && n < 500) begin @(negedge clk_i); n++; end
        check("hold_rsp_seen", rsp_valid_o, 1'b1);
        snap = rsp_data_o;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk_i);
            if (!(rsp_valid_o && rsp_data_o == snap && !req_ready_o && !tck_o)) stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_hs", {req_ready_o, rsp_valid_o}, 2'b10);

        // IR scan selects IDCODE, then a full 32-bit DR read.
        scan(1'b1, 5'd4, 32'h0000_0001, 32'h0000_0001, 64'h183, 10);
        scan(1'b0, 5'd31, 32'h0, IDCODE, 64'h6_0000_0001, 36);

        // Abort a 16-bit scan in shift step 3.
        wait_idle();
        req_ir_i = 1'b0; req_len_i = 5'd15; req_data_i = 32'h0000_0008; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (21) @(negedge clk_i);
        check("abort_pre_steps", tms_n, 5);
        check("abort_pre_tdi", tdi_o, 1'b1);
        trst_ni = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (2) @(negedge clk_i);
        reset_release("abort");
        scan(1'b0, 5'd3, 32'h0000_000F, 32'h0000_000E, 64'h61, 8);

        n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk_i); n++; end
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
